// File: rtl/dbg_wb_pkg.sv
// Shared types and constants for the byte-stream debug bus initiator.
// The optional auto-increment feature is enabled by defining DBG_WB_AUTOINC_EN.
package dbg_wb_pkg;

    typedef enum logic [2:0] {IDLE, ADDR, SEL, DATA, BUS, RESP} state_t;

    localparam logic [7:0] OP_WRITE      = 8'h01;
    localparam logic [7:0] OP_READ       = 8'h02;
    localparam logic [7:0] OP_READ_NEXT  = 8'h03;
    localparam logic [7:0] OP_WRITE_NEXT = 8'h04;

    localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;
    localparam logic [7:0] DEF_TMO_BYTE = 8'hE0;
    localparam logic [7:0] DEF_OK_BYTE  = 8'hA5;

    localparam int TMO_W = 16;

endpackage

// File: rtl/dbg_wb_timeout.sv
// Bus-cycle watchdog: loadable down-counter; expire marks the last allowed strobe cycle.
module dbg_wb_timeout
    import dbg_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= TMO_W'(TIMEOUT);
        else if (clr)
            cnt <= '0;
        else if (en && cnt != '0)
            cnt <= cnt - TMO_W'(1);
    end

    assign expire = en && (cnt == TMO_W'(1));

endmodule

// File: rtl/dbg_wb_master.sv
// Command-byte decoder driving single 32-bit bus cycles and returning a byte response.
// Define DBG_WB_AUTOINC_EN for address auto-increment and the *_NEXT opcodes.
module dbg_wb_master
    import dbg_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [7:0]  ERR_BYTE = DEF_ERR_BYTE,
    parameter logic [7:0]  TMO_BYTE = DEF_TMO_BYTE,
    parameter logic [7:0]  OK_BYTE  = DEF_OK_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [0:7]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [0:7]  tx_data,
    input  logic        tx_ready,
    output logic [0:23] adr_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [0:3]  sel_o,
    output logic [0:31] dat_o,
    input  logic        ack_i,
    input  logic [0:31] dat_i
);

`ifdef DBG_WB_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_t      state;
    logic        is_wr;
    logic [1:0]  cnt;
    logic [1:0]  tx_left;
    logic [23:0] adr_r;
    logic [23:0] rd_sh;
    logic        bus_act;
    logic [7:0]  byte_in;
    logic        rx_fire;
    logic        go_bus;
    logic        expire;

    assign byte_in = rx_data;
    assign rx_fire = rx_valid && rx_ready;
    assign adr_o   = {adr_r[23:2], 2'b00};
    assign cyc_o   = bus_act;
    assign stb_o   = bus_act;

    always_comb begin
        go_bus = 1'b0;
        case (state)
            IDLE:    go_bus = rx_fire && AUTOINC && byte_in == OP_READ_NEXT;
            ADDR:    go_bus = rx_fire && cnt == 2'd0 && !is_wr;
            DATA:    go_bus = rx_fire && cnt == 2'd0;
            default: go_bus = 1'b0;
        endcase
    end

    dbg_wb_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .load   (go_bus),
        .clr    (state != BUS),
        .en     (state == BUS),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            cnt      <= '0;
            tx_left  <= '0;
            adr_r    <= '0;
            rd_sh    <= '0;
            bus_act  <= 1'b0;
            we_o     <= 1'b0;
            sel_o    <= '0;
            dat_o    <= '0;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        if (byte_in == OP_WRITE || byte_in == OP_READ) begin
                            state <= ADDR;
                            cnt   <= 2'd2;
                            is_wr <= (byte_in == OP_WRITE);
                        end else if (AUTOINC && byte_in == OP_WRITE_NEXT) begin
                            state <= SEL;
                            is_wr <= 1'b1;
                        end else if (AUTOINC && byte_in == OP_READ_NEXT) begin
                            state <= BUS;
                            is_wr <= 1'b0;
                        end else begin
                            rx_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= ERR_BYTE;
                            tx_left  <= 2'd0;
                            state    <= RESP;
                        end
                    end
                end
                ADDR: if (rx_fire) begin
                    adr_r <= {adr_r[15:0], byte_in};
                    cnt   <= cnt - 2'd1;
                    if (cnt == 2'd0)
                        state <= is_wr ? SEL : BUS;
                end
                SEL: if (rx_fire) begin
                    sel_o <= byte_in[3:0];
                    cnt   <= 2'd3;
                    state <= DATA;
                end
                DATA: if (rx_fire) begin
                    dat_o <= {dat_o[8:31], byte_in};
                    cnt   <= cnt - 2'd1;
                    if (cnt == 2'd0)
                        state <= BUS;
                end
                BUS: begin
                    // ack in the expiry cycle still completes the access
                    if (ack_i) begin
                        bus_act  <= 1'b0;
                        we_o     <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                        if (is_wr) begin
                            tx_data <= OK_BYTE;
                            tx_left <= 2'd0;
                        end else begin
                            tx_data <= dat_i[0:7];
                            rd_sh   <= dat_i[8:31];
                            tx_left <= 2'd3;
                        end
                        if (AUTOINC)
                            adr_r[23:2] <= adr_r[23:2] + 22'd1;
                    end else if (expire) begin
                        bus_act  <= 1'b0;
                        we_o     <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= TMO_BYTE;
                        tx_left  <= 2'd0;
                        state    <= RESP;
                    end
                end
                RESP: if (tx_valid && tx_ready) begin
                    if (tx_left == 2'd0) begin
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tx_data <= rd_sh[23:16];
                        rd_sh   <= {rd_sh[15:0], 8'h00};
                        tx_left <= tx_left - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // bus cycle launch; reads present all lanes and zero write data
            if (go_bus) begin
                rx_ready <= 1'b0;
                bus_act  <= 1'b1;
                we_o     <= (state == DATA);
                if (state != DATA) begin
                    sel_o <= 4'hF;
                    dat_o <= '0;
                end
            end
        end
    end

endmodule

// File: doc/dbg_wb_master.md
Name: dbg_wb_master

Overview:
- Byte-stream-to-bus initiator: decodes command packets from a byte source (UART receive path) into single 32-bit bus read/write cycles on the soft-processor MMIO bus.
- Returns status/read data as a byte stream (UART transmit path).
- Drives the initiator side of the same adr/stb/cyc/sel/we/dat/ack bus the MMIO decoder responds on.
- Bus bit numbering is big-endian: bit 0 is the MSB.

Parameters:
TIMEOUT, 255, cycles to wait for ack_i before abandoning a bus cycle; legal range 1..65535
ERR_BYTE, 8'hEE, response byte for an unknown command
TMO_BYTE, 8'hE0, response byte for a bus timeout
OK_BYTE, 8'hA5, response byte for a completed write

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_valid  in  1  command byte available
rx_data  in  [0:7]  command byte
rx_ready  out  1  byte consumed when rx_valid && rx_ready
tx_valid  out  1  response byte available
tx_data  out  [0:7]  response byte
tx_ready  in  1  response byte taken when tx_valid && tx_ready
adr_o  out  [0:23]  bus byte address; bits 22:23 always 0
cyc_o  out  1  bus cycle
stb_o  out  1  bus strobe
we_o  out  1  write enable
sel_o  out  [0:3]  byte lanes; sel_o[0] = dat_o[0:7]
dat_o  out  [0:31]  write data
ack_i  in  1  bus acknowledge
dat_i  in  [0:31]  read data, valid with ack_i

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; state IDLE; counters cleared. Reset mid-bus-cycle drops cyc_o/stb_o immediately. A partial packet is discarded.

Packets (all multi-byte fields are MSB first):
- 0x01 WRITE: A2 A1 A0, S, D3 D2 D1 D0.
  - adr_o = {A2,A1,A0[0:5],2'b00}; sel_o = S[4:7]; dat_o = {D3..D0}.
  - Response: OK_BYTE.
- 0x02 READ: A2 A1 A0.
  - sel_o = 4'b1111.
  - Response: 4 bytes of dat_i, dat_i[0:7] first.
- Any other opcode (without the feature): respond ERR_BYTE; the opcode is the only byte consumed.

States:
- IDLE
  - rx_ready = 1.
  - Valid opcode -> ADDR (cnt=2). Invalid opcode -> RESP with ERR_BYTE.
- ADDR
  - rx_ready = 1; shifts one address byte per accepted byte.
  - After the 3rd byte: READ -> BUS; WRITE -> SEL.
- SEL
  - Accepts 1 byte -> DATA (cnt=3).
- DATA
  - Accepts 4 bytes, shifted into dat_o -> BUS.
- BUS
  - rx_ready = 0.
  - cyc_o = stb_o = 1 from the first cycle in BUS; we_o = 1 for WRITE.
  - Timer counts cycles with stb_o high.
  - ack_i seen: the cycle holding ack_i is the last with stb_o/cyc_o high; both drop the next cycle; dat_i captured on the ack cycle.
  - Timer reaches TIMEOUT without ack_i: drop cyc_o/stb_o -> RESP with TMO_BYTE. An ack arriving in the same cycle as expiry wins.
  - A late ack after timeout is ignored.
- RESP
  - tx_valid = 1; tx_data holds stable until accepted.
  - Read: 4 bytes, advancing per tx_valid && tx_ready.
  - After the last byte is accepted -> IDLE.
  - tx_ready held low stalls indefinitely; no bytes are lost.
- Throughput: at most one rx byte accepted per cycle; at most one tx byte sent per cycle.
- rx_ready and tx_valid are never both high.
- we_o, sel_o, and adr_o remain stable for the whole cycle.
- dat_o is 0 on reads.

Optional Feature:
Macro DBG_WB_AUTOINC_EN.
- Defined:
  - After every acked access, the internal address register increments by 4; it wraps from 0xFFFFFC to 0x000000.
  - Opcode 0x03 READ_NEXT: no address bytes; IDLE -> BUS.
  - Opcode 0x04 WRITE_NEXT: S and 4 data bytes follow; IDLE -> SEL.
  - A timed-out access does not increment the address.
- Undefined:
  - 0x03/0x04 are unknown opcodes -> ERR_BYTE.
  - The address register is not modified after access.

Decomposition:
- Package dbg_wb_pkg holds:
  - the state enum (IDLE, ADDR, SEL, DATA, BUS, RESP);
  - opcode constants OP_WRITE=8'h01, OP_READ=8'h02, OP_READ_NEXT=8'h03, OP_WRITE_NEXT=8'h04;
  - default response byte constants.
- One natural sub-module: dbg_wb_timeout, the loadable down-counter with clear and expire flag.
- Everything else stays in dbg_wb_master.

Test Plan:
- Feed 01 00 01 04 0F DE AD BE EF, responder acks after 2 cycles -> one cycle with adr_o=24'h000104, sel_o=4'hF, dat_o=32'hDEADBEEF, we_o=1; tx byte 0xA5.
- Feed 02 03 00 08, responder returns 32'h12345678 with ack on 1st cycle -> adr_o=24'h030008, we_o=0; tx bytes 12 34 56 78 in order.
- Feed 02 00 00 00, no ack, TIMEOUT=8 -> stb_o high exactly 8 cycles, then tx 0xE0; ack injected 3 cycles later is ignored; the next command works.
- Feed 7F -> tx 0xEE only; next byte 02 is treated as an opcode.
- Hold tx_ready low 20 cycles during a read response, and pulse reset low mid-BUS -> no byte lost or duplicated; reset drops cyc_o asynchronously; outputs return to 0.
- With DBG_WB_AUTOINC_EN: read at 0xFFFFFC then 03 -> second access at adr_o=24'h000000; without the macro, 03 -> 0xEE.
